// File: rtl/dm_pkg.sv
// Shared types and helpers for the byte-enabled data-memory controller.
package dm_pkg;

  localparam int unsigned DM_DATA_W      = 32;
  localparam int unsigned BYTES_PER_WORD = DM_DATA_W / 8;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } dm_state_e;

  // Lane merge for the default word width: lane k comes from new_word where byteen[k] is set.
  function automatic logic [DM_DATA_W-1:0] byte_merge(
    input logic [DM_DATA_W-1:0]      old_word,
    input logic [DM_DATA_W-1:0]      new_word,
    input logic [BYTES_PER_WORD-1:0] byteen
  );
    logic [DM_DATA_W-1:0] merged;
    merged = old_word;
    for (int k = 0; k < int'(BYTES_PER_WORD); k++) begin
      if (byteen[k]) merged[8*k +: 8] = new_word[8*k +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/byte_mem_ctrl_if.sv
// Request/response bus between the M-stage memory port and the data-memory controller.
interface byte_mem_ctrl_if #(
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic [31:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [BE_W-1:0]   req_byteen;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_addr, req_wdata, req_byteen, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wdata, req_byteen, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dm_byte_merge.sv
// Combinational byte-lane merge of a write into the existing memory word.
module dm_byte_merge #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0]   old_word,
  input  logic [DATA_W-1:0]   new_word,
  input  logic [DATA_W/8-1:0] byteen,
  output logic [DATA_W-1:0]   merged_c
);

  for (genvar k = 0; k < int'(DATA_W / 8); k++) begin : g_lane
    assign merged_c[8*k +: 8] = byteen[k] ? new_word[8*k +: 8] : old_word[8*k +: 8];
  end

endmodule

// File: rtl/byte_mem_ctrl.sv
// Data-memory controller: post-reset clear walk, wait states, byte-enable merge, range check.
// Optional write trace outputs (trc_*) are built when DM_WRITE_TRACE_EN is defined.
module byte_mem_ctrl
  import dm_pkg::*;
#(
  parameter int unsigned DATA_W      = DM_DATA_W,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  byte_mem_ctrl_if.slave    bus,
  output logic              busy
`ifdef DM_WRITE_TRACE_EN
  ,
  output logic              trc_valid,
  output logic [31:0]       trc_addr,
  output logic [DATA_W-1:0] trc_data
`endif
);

  localparam int unsigned BE_W = DATA_W / 8;
  localparam int unsigned AW   = $clog2(DEPTH_WORDS);
  localparam int unsigned CW   = 4;

  dm_state_e         state;
  logic [AW-1:0]     clr_idx;
  logic [CW-1:0]     wait_cnt;
  logic [AW-1:0]     lat_idx;
  logic [DATA_W-1:0] lat_wdata;
  logic [BE_W-1:0]   lat_byteen;
  logic              lat_in_range;
`ifdef DM_WRITE_TRACE_EN
  logic [31:0]       lat_addr;
`endif

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  logic [31:0]       off_c;
  logic [31:0]       idx_c;
  logic              in_range_c;
  logic              accept_c;
  logic              finish_c;
  logic              mem_we_c;
  logic [AW-1:0]     mem_addr_c;
  logic [DATA_W-1:0] mem_wdata_c;
  logic [DATA_W-1:0] old_word_c;
  logic [DATA_W-1:0] merged_c;

  // Range check at 32-bit width; the unsigned wrap below BASE_ADDR is caught by the >= test.
  always_comb begin
    off_c      = bus.req_addr - BASE_ADDR;
    idx_c      = off_c >> 2;
    in_range_c = (bus.req_addr >= BASE_ADDR) && (idx_c < 32'(DEPTH_WORDS));
    accept_c   = (state == ST_IDLE) && bus.req_valid && bus.req_ready;
    finish_c   = (state == ST_RESP) && !bus.rsp_valid;
  end

  assign old_word_c = mem[lat_idx];

  dm_byte_merge #(.DATA_W(DATA_W)) u_merge (
    .old_word (old_word_c),
    .new_word (lat_wdata),
    .byteen   (lat_byteen),
    .merged_c (merged_c)
  );

  // Single write port shared by the clear walk and the response-cycle write-back.
  always_comb begin
    mem_we_c    = 1'b0;
    mem_addr_c  = lat_idx;
    mem_wdata_c = merged_c;
    if (state == ST_CLEAR) begin
      mem_we_c    = 1'b1;
      mem_addr_c  = clr_idx;
      mem_wdata_c = '0;
    end else if (finish_c && lat_in_range && (|lat_byteen)) begin
      mem_we_c = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we_c) mem[mem_addr_c] <= mem_wdata_c;
  end

  // Control FSM with all bus outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_CLEAR;
      clr_idx       <= '0;
      wait_cnt      <= '0;
      lat_idx       <= '0;
      lat_wdata     <= '0;
      lat_byteen    <= '0;
      lat_in_range  <= 1'b0;
      bus.req_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      busy          <= 1'b1;
`ifdef DM_WRITE_TRACE_EN
      lat_addr      <= '0;
      trc_valid     <= 1'b0;
      trc_addr      <= '0;
      trc_data      <= '0;
`endif
    end else begin
`ifdef DM_WRITE_TRACE_EN
      trc_valid <= 1'b0;
`endif
      unique case (state)
        ST_CLEAR: begin
          clr_idx <= clr_idx + AW'(1);
          if (clr_idx == AW'(DEPTH_WORDS - 1)) begin
            state         <= ST_IDLE;
            busy          <= 1'b0;
            bus.req_ready <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (accept_c) begin
            bus.req_ready <= 1'b0;
            lat_idx       <= idx_c[AW-1:0];
            lat_wdata     <= bus.req_wdata;
            lat_byteen    <= bus.req_byteen;
            lat_in_range  <= in_range_c;
`ifdef DM_WRITE_TRACE_EN
            lat_addr      <= {bus.req_addr[31:2], 2'b00};
`endif
            if (WAIT_CYCLES == 0) begin
              state <= ST_RESP;
            end else begin
              state    <= ST_WAIT;
              wait_cnt <= CW'(WAIT_CYCLES);
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt <= CW'(1)) state <= ST_RESP;
          else                    wait_cnt <= wait_cnt - CW'(1);
        end
        ST_RESP: begin
          if (!bus.rsp_valid) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= !lat_in_range;
            if (!lat_in_range)     bus.rsp_rdata <= '0;
            else if (|lat_byteen)  bus.rsp_rdata <= merged_c;
            else                   bus.rsp_rdata <= old_word_c;
`ifdef DM_WRITE_TRACE_EN
            if (lat_in_range && (|lat_byteen)) begin
              trc_valid <= 1'b1;
              trc_addr  <= lat_addr;
              trc_data  <= merged_c;
            end
`endif
          end else if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_byte_mem_ctrl.sv
// Directed bench: DUT0 (no wait states, base 0) and DUT1 (3 wait states, base 0x1000), both 16 words.
module tb_byte_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, rst1;
  logic        rv [2];
  logic        rr [2];
  logic [31:0] ra, rw;
  logic [3:0]  rb;

  logic        o_rdy [2];
  logic        o_vld [2];
  logic        o_err [2];
  logic        o_busy [2];
  logic [31:0] o_rd [2];
  logic        busy0, busy1;

  int total = 0;
  int bad   = 0;

  byte_mem_ctrl_if #(.DATA_W(32)) bus0 ();
  byte_mem_ctrl_if #(.DATA_W(32)) bus1 ();

  assign bus0.req_valid  = rv[0];
  assign bus0.rsp_ready  = rr[0];
  assign bus0.req_addr   = ra;
  assign bus0.req_wdata  = rw;
  assign bus0.req_byteen = rb;
  assign bus1.req_valid  = rv[1];
  assign bus1.rsp_ready  = rr[1];
  assign bus1.req_addr   = ra;
  assign bus1.req_wdata  = rw;
  assign bus1.req_byteen = rb;

  assign o_rdy[0]  = bus0.req_ready;
  assign o_vld[0]  = bus0.rsp_valid;
  assign o_err[0]  = bus0.rsp_err;
  assign o_rd[0]   = bus0.rsp_rdata;
  assign o_busy[0] = busy0;
  assign o_rdy[1]  = bus1.req_ready;
  assign o_vld[1]  = bus1.rsp_valid;
  assign o_err[1]  = bus1.rsp_err;
  assign o_rd[1]   = bus1.rsp_rdata;
  assign o_busy[1] = busy1;

`ifdef DM_WRITE_TRACE_EN
  logic        trc_v0, trc_v1;
  logic [31:0] trc_a0, trc_a1, trc_d0, trc_d1;
  int          trc_cnt = 0;
  logic [31:0] trc_last_a = '0;
  logic [31:0] trc_last_d = '0;
  always @(negedge clk) begin
    if (trc_v0) begin
      trc_cnt    <= trc_cnt + 1;
      trc_last_a <= trc_a0;
      trc_last_d <= trc_d0;
    end
  end
`endif

  byte_mem_ctrl #(.DATA_W(32), .DEPTH_WORDS(16), .WAIT_CYCLES(0), .BASE_ADDR(32'h0000_0000)) u_dut0 (
    .clk   (clk),
    .reset (rst0),
    .bus   (bus0),
    .busy  (busy0)
`ifdef DM_WRITE_TRACE_EN
    ,
    .trc_valid (trc_v0),
    .trc_addr  (trc_a0),
    .trc_data  (trc_d0)
`endif
  );

  byte_mem_ctrl #(.DATA_W(32), .DEPTH_WORDS(16), .WAIT_CYCLES(3), .BASE_ADDR(32'h0000_1000)) u_dut1 (
    .clk   (clk),
    .reset (rst1),
    .bus   (bus1),
    .busy  (busy1)
`ifdef DM_WRITE_TRACE_EN
    ,
    .trc_valid (trc_v1),
    .trc_addr  (trc_a1),
    .trc_data  (trc_d1)
`endif
  );

  typedef struct packed {
    logic        s;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a request until accepted, then scrambles the inputs to prove they were latched.
  task automatic accept(input int s, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    int n;
    n = 0;
    ra = a; rw = d; rb = be; rv[s] = 1'b1;
    while (!o_rdy[s] && n < 100) begin
      step();
      n++;
    end
    chk("accept ready in time", 32'(o_rdy[s]), 32'd1);
    step();
    rv[s] = 1'b0;
    ra = 32'hFFFF_FFF0; rw = 32'h5A5A_5A5A; rb = 4'hF;
  endtask

  task automatic wait_rsp(input int s, output int lat);
    lat = 0;
    while (!o_vld[s] && lat < 100) begin
      step();
      lat++;
    end
    if (!o_vld[s]) chk("response in time", 32'(o_vld[s]), 32'd1);
  endtask

  task automatic txn(input int s, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                     output logic [31:0] rd, output logic e, output int lat);
    rr[s] = 1'b1;
    accept(s, a, d, be);
    wait_rsp(s, lat);
    rd = o_rd[s];
    e  = o_err[s];
    step();
  endtask

  task automatic wait_clear(input int s, output int n, output logic rdy_in_busy);
    n = 0;
    rdy_in_busy = 1'b0;
    do begin
      step();
      n++;
      if (o_busy[s] && o_rdy[s]) rdy_in_busy = 1'b1;
    end while (o_busy[s] && n < 100);
  endtask

  initial begin
    vec_t        tbl [22];
    logic [31:0] rd;
    logic        e;
    int          lat;
    int          n;
    logic        rib;

    tbl[0]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'b0000, 32'h0000_0000, 1'b0};
    tbl[1]  = '{1'b0, 32'h0000_000C, 32'hAABB_CCDD, 4'b1111, 32'hAABB_CCDD, 1'b0};
    tbl[2]  = '{1'b0, 32'h0000_000E, 32'h1122_3344, 4'b0010, 32'hAABB_33DD, 1'b0};
    tbl[3]  = '{1'b0, 32'h0000_000C, 32'h0000_0000, 4'b0000, 32'hAABB_33DD, 1'b0};
    tbl[4]  = '{1'b0, 32'h0000_0040, 32'h0000_0000, 4'b0000, 32'h0000_0000, 1'b1};
    tbl[5]  = '{1'b0, 32'h0000_0040, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0000, 1'b1};
    tbl[6]  = '{1'b0, 32'h0000_003C, 32'h0000_0000, 4'b0000, 32'h0000_0000, 1'b0};
    tbl[7]  = '{1'b0, 32'h0000_003C, 32'h0102_0304, 4'b0101, 32'h0002_0004, 1'b0};
    tbl[8]  = '{1'b0, 32'h0000_003F, 32'h0000_0000, 4'b0000, 32'h0002_0004, 1'b0};
    tbl[9]  = '{1'b0, 32'h0000_0004, 32'hFFFF_FFFF, 4'b1111, 32'hFFFF_FFFF, 1'b0};
    tbl[10] = '{1'b0, 32'h0000_0004, 32'h1234_5678, 4'b1000, 32'h12FF_FFFF, 1'b0};
    tbl[11] = '{1'b0, 32'h0000_0004, 32'h0000_0000, 4'b0000, 32'h12FF_FFFF, 1'b0};
    tbl[12] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'b0000, 32'h0000_0000, 1'b0};
    tbl[13] = '{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 4'b0000, 32'h0000_0000, 1'b1};
    tbl[14] = '{1'b0, 32'h0000_0008, 32'h0000_0000, 4'b0000, 32'h0000_0000, 1'b0};
    tbl[15] = '{1'b1, 32'h0000_1008, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 1'b0};
    tbl[16] = '{1'b1, 32'h0000_0FFC, 32'h0000_0000, 4'b0000, 32'h0000_0000, 1'b1};
    tbl[17] = '{1'b1, 32'h0000_0FFC, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0000, 1'b1};
    tbl[18] = '{1'b1, 32'h0000_1040, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0000, 1'b1};
    tbl[19] = '{1'b1, 32'h0000_1000, 32'h0000_0000, 4'b0000, 32'h0000_0000, 1'b0};
    tbl[20] = '{1'b1, 32'h0000_103C, 32'h0000_0000, 4'b0000, 32'h0000_0000, 1'b0};
    tbl[21] = '{1'b1, 32'h0000_100A, 32'h0000_0000, 4'b0000, 32'hCAFE_F00D, 1'b0};

    rst0 = 1'b0; rst1 = 1'b0;
    rv[0] = 1'b0; rv[1] = 1'b0; rr[0] = 1'b1; rr[1] = 1'b1;
    ra = '0; rw = '0; rb = '0;
    repeat (2) step();
    chk("reset busy",      32'(o_busy[0]), 32'd1);
    chk("reset req_ready", 32'(o_rdy[0]),  32'd0);
    chk("reset rsp_valid", 32'(o_vld[0]),  32'd0);
    chk("reset rsp_rdata", o_rd[0],        32'd0);
    chk("reset rsp_err",   32'(o_err[0]),  32'd0);

    // Abort the clear walk five cycles in, then let it run in full.
    @(negedge clk) rst0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("walk busy", 32'(o_busy[0]), 32'd1);
    end
    rst0 = 1'b0;
    #1;
    chk("mid-walk reset busy",  32'(o_busy[0]), 32'd1);
    chk("mid-walk reset ready", 32'(o_rdy[0]),  32'd0);
    @(negedge clk) rst0 = 1'b1;
    wait_clear(0, n, rib);
    chk("clear cycles dut0",     32'(n),         32'd16);
    chk("ready during clear",    32'(rib),       32'd0);
    chk("ready after clear",     32'(o_rdy[0]),  32'd1);
`ifdef DM_WRITE_TRACE_EN
    chk("trace pulses in clear", 32'(trc_cnt),   32'd0);
`endif
    @(negedge clk) rst1 = 1'b1;
    wait_clear(1, n, rib);
    chk("clear cycles dut1", 32'(n), 32'd16);

    for (int i = 0; i < 22; i++) begin
      txn(int'(tbl[i].s), tbl[i].addr, tbl[i].wdata, tbl[i].be, rd, e, lat);
      chk($sformatf("vec%0d rdata", i),   rd,      tbl[i].exp_rd);
      chk($sformatf("vec%0d err", i),     32'(e),  32'(tbl[i].exp_err));
      chk($sformatf("vec%0d latency", i), 32'(lat), tbl[i].s ? 32'd4 : 32'd1);
      if (i == 14) begin
`ifdef DM_WRITE_TRACE_EN
        chk("trace pulse count", 32'(trc_cnt), 32'd5);
        chk("trace addr",        trc_last_a,   32'h0000_0004);
        chk("trace data",        trc_last_d,   32'h12FF_FFFF);
`endif
      end
    end

    // Response held with rsp_ready low: outputs stay put and no new request is offered.
    rr[1] = 1'b0;
    accept(1, 32'h0000_1008, 32'h0, 4'b0000);
    wait_rsp(1, lat);
    chk("hold latency", 32'(lat), 32'd4);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold rsp_valid", 32'(o_vld[1]), 32'd1);
      chk("hold rsp_rdata", o_rd[1],       32'hCAFE_F00D);
      chk("hold req_ready", 32'(o_rdy[1]), 32'd0);
    end
    rr[1] = 1'b1;
    step();
    chk("consume rsp_valid", 32'(o_vld[1]), 32'd0);
    chk("consume req_ready", 32'(o_rdy[1]), 32'd1);

    // Reset during a pending response clears outputs at once and restarts the walk.
    rr[1] = 1'b0;
    accept(1, 32'h0000_1008, 32'h0, 4'b0000);
    wait_rsp(1, lat);
    chk("pre-reset rdata", o_rd[1], 32'hCAFE_F00D);
    rst1 = 1'b0;
    #1;
    chk("resp reset rsp_valid", 32'(o_vld[1]),  32'd0);
    chk("resp reset rsp_rdata", o_rd[1],        32'd0);
    chk("resp reset rsp_err",   32'(o_err[1]),  32'd0);
    chk("resp reset busy",      32'(o_busy[1]), 32'd1);
    chk("resp reset req_ready", 32'(o_rdy[1]),  32'd0);
    @(negedge clk) begin
      rst1 = 1'b1;
      rr[1] = 1'b1;
    end
    wait_clear(1, n, rib);
    chk("reclear cycles dut1", 32'(n), 32'd16);
    txn(1, 32'h0000_1008, 32'h0, 4'b0000, rd, e, lat);
    chk("cleared word after reset", rd, 32'h0000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
